stopwatch_core: RTL and testbench

Parametrised stopwatch timebase and counter for the 7-segment display path. Takes debounced single-cycle control pulses, divides clk into a count tick, and drives a chain of NUM_DIGITS cascaded BCD digits. Adds a proper run/pause/stop control FSM, selectable overflow mode and tick strobe output. Feeds the existing siebensegment multiplexer; instances of entprellt sit upstream.

---
 rtl/stopwatch_core.sv | 157 +++++++++++++++
 tb/tb_stopwatch_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core: run/pause/stop stopwatch driving a cascaded BCD digit chain.
// Define LAP_CAPTURE_EN to build the lap-hold display register.
module stopwatch_core #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 5000000,
   parameter int DIV_W      = 23,
   parameter int WRAP       = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    stop,
   input  logic                    clear,
   input  logic                    lap,
   output logic [NUM_DIGITS*4-1:0] digits,
   output logic                    tick,
   output logic                    running,
   output logic                    overflow,
   output logic [1:0]              state
);
   localparam int DW = NUM_DIGITS * 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      STOPPED = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] pre_q, pre_d;
   logic [DW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic             tick_q, ovf_q, ovf_d;
   logic [4:0]       cmd_q, cmd_rise;
   logic             lap_r, clr_r, stp_r, pse_r, sta_r;
   logic             wrap, full, sat;

   // Only the rising edge of each command input acts.
   assign cmd_rise = {lap, clear, stop, pause, start} & ~cmd_q;
   assign {lap_r, clr_r, stp_r, pse_r, sta_r} = cmd_rise;

   assign wrap = (state_q == RUN) && (pre_q == DIV_W'(TICK_DIV - 1));
   assign sat  = wrap && full && (WRAP == 0);

   always_comb begin
      logic c;
      c       = 1'b1;
      cnt_inc = cnt_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c) begin
            if (cnt_q[4*i +: 4] == 4'd9) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      full = c;
   end

   always_comb begin
      pre_d = pre_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (state_q == RUN) pre_d = wrap ? '0 : pre_q + 1'b1;
      if (wrap && !sat) cnt_d = cnt_inc;
      if (wrap && full) ovf_d = 1'b1;
      if (clr_r) begin
         pre_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clr_r) begin
         state_d = IDLE;
      end else if (sat) begin
         state_d = STOPPED;
      end else if (stp_r) begin
         if (state_q == RUN || state_q == PAUSED) state_d = STOPPED;
      end else if (pse_r) begin
         if (state_q == RUN)         state_d = PAUSED;
         else if (state_q == PAUSED) state_d = RUN;
      end else if (sta_r) begin
         if (state_q == IDLE || state_q == PAUSED) state_d = RUN;
      end
   end

   always_comb begin
      running  = (state_q == RUN);
      state    = state_q;
      tick     = tick_q;
      overflow = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         tick_q  <= wrap;
         ovf_q   <= ovf_d;
         cmd_q   <= {lap, clear, stop, pause, start};
      end
   end

`ifdef LAP_CAPTURE_EN
   logic          hold_q, hold_d;
   logic [DW-1:0] lap_q, lap_d, disp_q, disp_d;

   always_comb begin
      hold_d = hold_q;
      lap_d  = lap_q;
      if (clr_r || stp_r) begin
         hold_d = 1'b0;
      end else if (lap_r) begin
         if (hold_q) begin
            hold_d = 1'b0;
         end else if (state_q == RUN) begin
            hold_d = 1'b1;
            lap_d  = cnt_q;
         end
      end
      disp_d = hold_d ? lap_d : cnt_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_q <= 1'b0;
         lap_q  <= '0;
         disp_q <= '0;
      end else begin
         hold_q <= hold_d;
         lap_q  <= lap_d;
         disp_q <= disp_d;
      end
   end

   assign digits = disp_q;
`else
   logic unused_lap;
   assign unused_lap = lap_r;
   assign digits     = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: vector table, directed corner sequences and a random
// run against an integer-count reference model, for WRAP=0 and WRAP=1.
module tb_stopwatch_core;
   localparam int TD = 4;

   localparam bit [4:0] N = 5'b00000;
   localparam bit [4:0] S = 5'b00001;
   localparam bit [4:0] P = 5'b00010;
   localparam bit [4:0] T = 5'b00100;
   localparam bit [4:0] C = 5'b01000;
   localparam bit [4:0] L = 5'b10000;

   logic clk = 1'b0;
   logic reset_n;
   logic start, pause, stop, clear, lap;
   logic [1:0][7:0] dig;
   logic [1:0]      tk, run, ov;
   logic [1:0][1:0] st;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stopwatch_core #(
      .NUM_DIGITS(2), .TICK_DIV(TD), .DIV_W(3), .WRAP(0)
   ) u_sat (
      .clk(clk), .reset_n(reset_n),
      .start(start), .pause(pause), .stop(stop),
      .clear(clear), .lap(lap),
      .digits(dig[0]), .tick(tk[0]), .running(run[0]),
      .overflow(ov[0]), .state(st[0])
   );

   stopwatch_core #(
      .NUM_DIGITS(2), .TICK_DIV(TD), .DIV_W(3), .WRAP(1)
   ) u_wrap (
      .clk(clk), .reset_n(reset_n),
      .start(start), .pause(pause), .stop(stop),
      .clear(clear), .lap(lap),
      .digits(dig[1]), .tick(tk[1]), .running(run[1]),
      .overflow(ov[1]), .state(st[1])
   );

   typedef struct {
      int st;
      int pre;
      int cnt;
      bit ov;
      bit tk;
      bit hold;
      int lapv;
   } mdl_t;

   mdl_t     m [2];
   bit [4:0] prev;

   typedef struct {
      bit [4:0] in;
      int       st;
      int       dg;
      bit       tk;
   } vec_t;

   vec_t tbl [12];

   function automatic int bcd(input int n);
      return (n / 10) * 16 + (n % 10);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m[k].st = 0; m[k].pre = 0; m[k].cnt = 0; m[k].ov = 0;
         m[k].tk = 0; m[k].hold = 0; m[k].lapv = 0;
      end
      prev = '0;
   endtask

   // Integer-count model: k=0 saturates at 99, k=1 rolls over to 0.
   task automatic model_step(input bit [4:0] in);
      bit [4:0] r;
      mdl_t     o, n;
      bit       inc, satk;
      r    = in & ~prev;
      prev = in;
      for (int k = 0; k < 2; k++) begin
         o    = m[k];
         n    = o;
         inc  = (o.st == 1) && (o.pre == TD - 1);
         satk = inc && (o.cnt == 99) && (k == 0);
         n.tk = inc;
         if (o.st == 1) n.pre = (o.pre + 1) % TD;
         if (inc) begin
            n.cnt = (o.cnt + 1) % 100;
            if (o.cnt == 99) begin
               n.ov = 1;
               if (k == 0) n.cnt = 99;
            end
         end
         if (satk) n.st = 3;
         else if (r[2]) begin
            if (o.st == 1 || o.st == 2) n.st = 3;
         end else if (r[1]) begin
            if (o.st == 1) n.st = 2;
            else if (o.st == 2) n.st = 1;
         end else if (r[0]) begin
            if (o.st == 0 || o.st == 2) n.st = 1;
         end
`ifdef LAP_CAPTURE_EN
         if (r[3] || r[2]) n.hold = 0;
         else if (r[4]) begin
            if (o.hold) n.hold = 0;
            else if (o.st == 1) begin
               n.hold = 1;
               n.lapv = o.cnt;
            end
         end
`endif
         if (r[3]) begin
            n.st = 0; n.cnt = 0; n.pre = 0; n.ov = 0;
         end
         m[k] = n;
      end
   endtask

   task automatic check_model();
      int e;
      for (int k = 0; k < 2; k++) begin
         e = m[k].hold ? m[k].lapv : m[k].cnt;
         chk($sformatf("mdl_digits%0d", k), int'(dig[k]), bcd(e));
         chk($sformatf("mdl_tick%0d", k), int'(tk[k]), int'(m[k].tk));
         chk($sformatf("mdl_state%0d", k), int'(st[k]), m[k].st);
         chk($sformatf("mdl_running%0d", k), int'(run[k]), int'(m[k].st == 1));
         chk($sformatf("mdl_overflow%0d", k), int'(ov[k]), int'(m[k].ov));
      end
   endtask

   task automatic cyc(input bit [4:0] in);
      @(negedge clk);
      {lap, clear, stop, pause, start} = in;
      @(posedge clk);
      model_step(in);
      #1;
      check_model();
   endtask

   initial begin
      tbl[0]  = '{S, 1, 8'h00, 1'b0};
      tbl[1]  = '{N, 1, 8'h00, 1'b0};
      tbl[2]  = '{N, 1, 8'h00, 1'b0};
      tbl[3]  = '{N, 1, 8'h00, 1'b0};
      tbl[4]  = '{N, 1, 8'h01, 1'b1};
      tbl[5]  = '{N, 1, 8'h01, 1'b0};
      tbl[6]  = '{N, 1, 8'h01, 1'b0};
      tbl[7]  = '{N, 1, 8'h01, 1'b0};
      tbl[8]  = '{N, 1, 8'h02, 1'b1};
      tbl[9]  = '{P, 2, 8'h02, 1'b0};
      tbl[10] = '{N, 2, 8'h02, 1'b0};
      tbl[11] = '{P, 1, 8'h02, 1'b0};

      reset_n = 1'b0;
      {lap, clear, stop, pause, start} = N;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_digits", int'(dig[k]), 0);
         chk("rst_tick", int'(tk[k]), 0);
         chk("rst_running", int'(run[k]), 0);
         chk("rst_overflow", int'(ov[k]), 0);
         chk("rst_state", int'(st[k]), 0);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].in);
         chk($sformatf("tbl%0d_state", i), int'(st[0]), tbl[i].st);
         chk($sformatf("tbl%0d_digits", i), int'(dig[0]), tbl[i].dg);
         chk($sformatf("tbl%0d_tick", i), int'(tk[0]), int'(tbl[i].tk));
         chk($sformatf("tbl%0d_running", i), int'(run[0]), int'(tbl[i].st == 1));
      end

      // pause keeps the fractional tick across a long pause
      cyc(C);
      cyc(S);
      repeat (5) cyc(N);
      cyc(P);
      for (int i = 0; i < 20; i++) begin
         cyc(N);
         chk("paused_digits", int'(dig[0]), 8'h01);
         chk("paused_state", int'(st[0]), 2);
      end
      cyc(P);
      chk("resume_state", int'(st[0]), 1);
      cyc(N);
      chk("resume1_digits", int'(dig[0]), 8'h01);
      chk("resume1_tick", int'(tk[0]), 0);
      cyc(N);
      chk("resume2_digits", int'(dig[0]), 8'h02);
      chk("resume2_tick", int'(tk[0]), 1);

      // full scale, both overflow modes
      cyc(C);
      cyc(S);
      repeat (396) cyc(N);
      chk("fs99_sat", int'(dig[0]), 8'h99);
      chk("fs99_wrap", int'(dig[1]), 8'h99);
      chk("fs99_ovf", int'(ov[0]), 0);
      repeat (4) cyc(N);
      chk("sat_digits", int'(dig[0]), 8'h99);
      chk("sat_ovf", int'(ov[0]), 1);
      chk("sat_state", int'(st[0]), 3);
      chk("wrap_digits", int'(dig[1]), 8'h00);
      chk("wrap_ovf", int'(ov[1]), 1);
      chk("wrap_state", int'(st[1]), 1);
      cyc(S);
      chk("stopped_start_state", int'(st[0]), 3);
      chk("stopped_start_digits", int'(dig[0]), 8'h99);
      cyc(C);
      chk("clr_state", int'(st[0]), 0);
      chk("clr_digits", int'(dig[0]), 8'h00);
      chk("clr_ovf", int'(ov[0]), 0);

      // clear beats stop; held start acts once
      cyc(S);
      repeat (3) cyc(N);
      cyc(C | T);
      chk("clrstop_state", int'(st[0]), 0);
      chk("clrstop_digits", int'(dig[0]), 8'h00);
      for (int i = 0; i < 10; i++) cyc(i == 5 ? (S | P) : S);
      cyc(N);
      chk("held_start_state", int'(st[0]), 2);
      cyc(C);

      // lap capture (live count when the feature is not built)
      cyc(S);
      repeat (28) cyc(N);
      chk("lap_pre_digits", int'(dig[0]), 8'h07);
      cyc(L);
      chk("lap_cap_digits", int'(dig[0]), 8'h07);
      repeat (11) cyc(N);
`ifdef LAP_CAPTURE_EN
      chk("lap_hold_digits", int'(dig[0]), 8'h07);
`else
      chk("lap_hold_digits", int'(dig[0]), 8'h10);
`endif
      repeat (8) cyc(N);
      cyc(L);
      chk("lap_release_digits", int'(dig[0]), 8'h12);

      cyc(C);
      for (int i = 0; i < 3000; i++) begin
         bit [4:0] in;
         in = N;
         if ($urandom_range(7) == 0)  in[0] = 1'b1;
         if ($urandom_range(9) == 0)  in[1] = 1'b1;
         if ($urandom_range(39) == 0) in[2] = 1'b1;
         if ($urandom_range(79) == 0) in[3] = 1'b1;
         if ($urandom_range(11) == 0) in[4] = 1'b1;
         cyc(in);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
